// File: rtl/hazard_ctrl_if.sv
// Bundle of the hazard controller's pipeline-facing signals: hazard sources
// coming in from the datapath and the register enables/flushes going back.
interface hazard_ctrl_if #(
  parameter int REG_W = 5,
  parameter int CNT_W = 32
);
  logic             ihit;
  logic             dhit;
  logic             exmem_dren;
  logic             exmem_dwen;
  logic             idex_memread;
  logic [REG_W-1:0] idex_rd;
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             ex_branch_take;
  logic             id_halt;
  logic             pc_en;
  logic             ifid_en;
  logic             ifid_flush;
  logic             idex_en;
  logic             idex_flush;
  logic             exmem_en;
  logic             memwb_en;
  logic             memwb_flush;
  logic             halt;
  logic [CNT_W-1:0] stall_cnt;

  // Datapath side: reports hazards, consumes enables.
  modport master (
    output ihit, dhit, exmem_dren, exmem_dwen, idex_memread, idex_rd,
           id_rs, id_rt, ex_branch_take, id_halt,
    input  pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en,
           memwb_en, memwb_flush, halt, stall_cnt
  );

  // Controller side.
  modport slave (
    input  ihit, dhit, exmem_dren, exmem_dwen, idex_memread, idex_rd,
           id_rs, id_rt, ex_branch_take, id_halt,
    output pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en,
           memwb_en, memwb_flush, halt, stall_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer for the 5-stage core: generates PC and pipeline-register
// enables/flushes from cache hits, load-use hazards, taken branches and HALT.
// Freezes the whole pipe on a data-cache miss, drains it on HALT, and counts
// stall cycles.
module hazard_ctrl #(
  parameter int REG_W      = 5,
  parameter int HALT_DRAIN = 3,
  parameter int CNT_W      = 32
) (
  input  logic         CLK,
  input  logic         nRST,
  hazard_ctrl_if.slave bus
);
  localparam int DC_W = (HALT_DRAIN < 2) ? 1 : $clog2(HALT_DRAIN + 1);
  localparam logic [DC_W-1:0] DRAIN_INIT = DC_W'(HALT_DRAIN);
  localparam logic [DC_W-1:0] DRAIN_LAST = DC_W'(1);

  typedef enum logic [1:0] {RUN, DMEM_WAIT, DRAIN, HALTED} state_t;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic ifid_flush;
    logic idex_en;
    logic idex_flush;
    logic exmem_en;
    logic memwb_en;
    logic memwb_flush;
  } ctl_t;

  localparam ctl_t CTL_FREEZE = 8'b0000_0001;
  localparam ctl_t CTL_DRAIN  = 8'b0111_0110;
  localparam ctl_t CTL_IDLE   = 8'b0000_0000;

  state_t           state, next_state;
  logic [DC_W-1:0]  drain_cnt, next_cnt;
  logic             drain_ret, next_ret;
  logic             halt_q;
  logic [CNT_W-1:0] stall_q;
  ctl_t             ctl;

  logic dmiss;
  logic load_use;

  assign dmiss    = (bus.exmem_dren | bus.exmem_dwen) & ~bus.dhit;
  assign load_use = bus.idex_memread && (bus.idex_rd != '0) &&
                    ((bus.idex_rd == bus.id_rs) || (bus.idex_rd == bus.id_rt));

  // Normal-flow controls: branch kill beats load-use stall beats IF bubble.
  function automatic ctl_t run_ctl(input logic branch, input logic lu,
                                   input logic bubble);
    ctl_t c;
    c = 8'b1101_0110;
    if (branch) begin
      c.ifid_flush = 1'b1;
      c.idex_flush = 1'b1;
    end else if (lu) begin
      c.pc_en      = 1'b0;
      c.ifid_en    = 1'b0;
      c.idex_flush = 1'b1;
    end else if (bubble) begin
      c.pc_en      = 1'b0;
      c.ifid_flush = 1'b1;
    end
    return c;
  endfunction

  // State, drain bookkeeping, sticky halt and stall counter.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= RUN;
      drain_cnt <= '0;
      drain_ret <= 1'b0;
      halt_q    <= 1'b0;
      stall_q   <= '0;
    end else begin
      state     <= next_state;
      drain_cnt <= next_cnt;
      drain_ret <= next_ret;
      halt_q    <= halt_q | (next_state == HALTED);
      if (!ctl.pc_en && state != HALTED) stall_q <= stall_q + 1'b1;
    end
  end

  // Next state; the dhit cycle that leaves DMEM_WAIT back into a drain is an
  // advancing cycle, so it consumes one drain count like a DRAIN cycle.
  always_comb begin
    next_state = state;
    next_cnt   = drain_cnt;
    next_ret   = drain_ret;
    case (state)
      RUN: begin
        if (dmiss) begin
          next_state = DMEM_WAIT;
          next_ret   = 1'b0;
        end else if (!bus.ex_branch_take && !load_use && bus.id_halt) begin
          next_state = DRAIN;
          next_cnt   = DRAIN_INIT;
        end
      end
      DMEM_WAIT: begin
        if (bus.dhit) begin
          if (drain_ret) begin
            next_cnt   = drain_cnt - 1'b1;
            next_state = (drain_cnt == DRAIN_LAST) ? HALTED : DRAIN;
          end else begin
            next_state = RUN;
          end
        end
      end
      DRAIN: begin
        if (dmiss) begin
          next_state = DMEM_WAIT;
          next_ret   = 1'b1;
        end else begin
          next_cnt   = drain_cnt - 1'b1;
          next_state = (drain_cnt == DRAIN_LAST) ? HALTED : DRAIN;
        end
      end
      default: next_state = HALTED;
    endcase
  end

  // Output decode per state; frozen states ignore branch/load-use until dhit.
  always_comb begin
    ctl = CTL_IDLE;
    case (state)
      RUN:
        ctl = dmiss ? CTL_FREEZE
                    : run_ctl(bus.ex_branch_take, load_use,
                              ~bus.ihit | bus.id_halt);
      DMEM_WAIT:
        if (!bus.dhit)     ctl = CTL_FREEZE;
        else if (drain_ret) ctl = CTL_DRAIN;
        else               ctl = run_ctl(bus.ex_branch_take, load_use, ~bus.ihit);
      DRAIN:
        ctl = dmiss ? CTL_FREEZE : CTL_DRAIN;
      default:
        ctl = CTL_IDLE;
    endcase
  end

  assign bus.pc_en       = nRST & ctl.pc_en;
  assign bus.ifid_en     = nRST & ctl.ifid_en;
  assign bus.ifid_flush  = nRST & ctl.ifid_flush;
  assign bus.idex_en     = nRST & ctl.idex_en;
  assign bus.idex_flush  = nRST & ctl.idex_flush;
  assign bus.exmem_en    = nRST & ctl.exmem_en;
  assign bus.memwb_en    = nRST & ctl.memwb_en;
  assign bus.memwb_flush = nRST & ctl.memwb_flush;
  assign bus.halt        = halt_q;
  assign bus.stall_cnt   = stall_q;
endmodule
